// File: rtl/seq_serializer.sv
// seq_serializer
//   Parallel-to-serial front end. Accepts WIDTH-bit words over a valid/ready
//   handshake and emits them one bit per clock on seq_out. A one-word holding
//   register lets a second word wait while the first is shifting, so
//   back-to-back words stream with no idle cycle between them.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_LEVEL seq_out level whenever no data bit is being sent
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   data_in    parallel word to serialize
//   data_valid data_in holds a word
//   data_ready block can take a word this cycle (= hold register empty)
//   seq_out    serial bit
//   seq_valid  seq_out carries a real data bit
//   last_bit   current bit is the final bit of its word
//   state_out  {hold_full, seq_valid}, debug status
module seq_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             last_bit,
  output logic [1:0]       state_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_shifted;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic             accept;
  logic             first_bit;

  assign data_ready = ~hold_full;
  assign accept     = data_valid & data_ready;

  // Shift toward the end that leaves first, back-filling with zeros.
  always_comb begin
    sh_shifted = '0;
    first_bit  = 1'b0;
    if (MSB_FIRST) begin
      sh_shifted = {sh[WIDTH-2:0], 1'b0};
      first_bit  = sh[WIDTH-1];
    end else begin
      sh_shifted = {1'b0, sh[WIDTH-1:1]};
      first_bit  = sh[0];
    end
  end

  assign seq_valid = (state == ST_SHIFT);
  assign seq_out   = seq_valid ? first_bit : IDLE_LEVEL;
  assign last_bit  = seq_valid & (cnt == LAST_CNT);
  assign state_out = {hold_full, seq_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sh        <= '0;
      hold      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sh    <= data_in;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt != LAST_CNT) begin
            sh  <= sh_shifted;
            cnt <= cnt + CW'(1);
            if (accept) begin
              hold      <= data_in;
              hold_full <= 1'b1;
            end
          end else if (hold_full) begin
            // Word boundary with a word waiting: chain it in with no gap.
            // data_ready is low this cycle, so no new word can arrive.
            sh        <= hold;
            cnt       <= '0;
            hold_full <= 1'b0;
          end else if (accept) begin
            // Word arrived exactly on the last bit: load it straight in.
            sh  <= data_in;
            cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
Parallel-to-serial front end that converts WIDTH-bit words into the one-bit-per-clock stream consumed on seq_in by seq_det_non_overlap. It has a valid/ready word input and a one-word holding register, so back-to-back words stream with no idle gap. seq_valid marks live bits, and state_out exposes internal status for bench monitoring.

Parameters:
WIDTH, 8, word width in bits (minimum 2)
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first
IDLE_LEVEL, 0, seq_out level whenever no bit is being sent

Ports:
clk  input  1  system clock, all flops rising-edge
rst_n  input  1  asynchronous active-low reset
data_in  input  WIDTH  parallel word to serialize
data_valid  input  1  data_in holds a word
data_ready  output  1  block can take a word this cycle
seq_out  output  1  serial bit, feeds the detector's seq_in
seq_valid  output  1  seq_out carries a real data bit
last_bit  output  1  current bit is the final bit of its word
state_out  output  2  {hold_full, shifting}, debug status

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Internal state: shift register sh[WIDTH]; bit counter cnt[clog2(WIDTH)]; hold register hold[WIDTH]; flag hold_full; FSM with states IDLE and SHIFT.
- Reset values: rst_n low clears all registers immediately, without waiting for a clock edge.
  - FSM = IDLE; sh = 0; cnt = 0; hold_full = 0.
  - seq_out = IDLE_LEVEL; seq_valid = 0; last_bit = 0; state_out = 00; data_ready = 1.
  - A word presented while rst_n is low is not accepted.
- Word accept: accept = data_valid & data_ready. data_ready = ~hold_full, combinational.
- Output decode, combinational from registers:
  - seq_valid = (FSM == SHIFT).
  - seq_out = first-out bit of sh when in SHIFT, else IDLE_LEVEL. The first-out bit is sh[WIDTH-1] when MSB_FIRST = 1, else sh[0].
  - last_bit = SHIFT & (cnt == WIDTH-1).
  - state_out = {hold_full, seq_valid}.
- IDLE, at a clock edge with accept: sh <= data_in; cnt <= 0; FSM <= SHIFT. The first bit appears on seq_out in the cycle after the accepting edge, so latency is 1 clock.
- IDLE, without accept: no change.
- SHIFT with cnt < WIDTH-1:
  - sh shifts toward the first-out end, filling with 0; cnt <= cnt+1.
  - If accept: hold <= data_in; hold_full <= 1.
- SHIFT with cnt == WIDTH-1 (word boundary):
  - If hold_full: sh <= hold; cnt <= 0; hold_full <= 0; FSM stays SHIFT. No gap between words.
  - Else if accept: sh <= data_in; cnt <= 0; FSM stays SHIFT. This is a direct load, with no gap.
  - Else: FSM <= IDLE.
- Boundary conditions:
  - Hold full: data_ready = 0 and data_valid is ignored. The source holds its word until data_ready returns high.
  - Simultaneous boundary, hold_full and data_valid: the hold word is loaded into sh, and data_ready reads 0 in that cycle. The new word is accepted in the next cycle at the earliest.
  - Reset in mid-word: the word in flight and the held word are both discarded. seq_out returns to IDLE_LEVEL asynchronously. After release, the block waits in IDLE.
- Sustained throughput: one bit per clock. Continuous valid input gives seq_valid permanently high.

Test Plan:
1. WIDTH=4, MSB_FIRST=1; accept 4'b1010 at edge E0 -> seq_out 1,0,1,0 in the 4 cycles after E0. seq_valid high for exactly those 4 cycles; last_bit high on the 4th. Then seq_out=0, state_out=00.
2. MSB_FIRST=0; send 4'b0011 -> seq_out 1,1,0,0.
3. Back-to-back: accept 4'b0101 at E0 and 4'b1010 at E1 -> data_ready low from E1 until E4. The 8-bit stream 0,1,0,1,1,0,1,0 is contiguous, with seq_valid high for 8 cycles.
4. Direct boundary load: hold empty, data_valid asserted exactly in the last_bit cycle of 4'b1100 with data_in=4'b0110 -> stream 1,1,0,0,0,1,1,0 with no gap. state_out stays 01 throughout.
5. Reset mid-word: pull rst_n low 0.5 clk after the 2nd bit of 4'b1111, with a word held -> seq_out=0, seq_valid=0 and state_out=00 immediately. After release, no bits are sent until a new accept.
6. Integration: chain into seq_det_non_overlap and stream words 4'b0010, 4'b1000, 4'b0101 (bit sequence 0010_1000_0101) -> detector output matches the bit-level directed test of that block, with timing shifted by the serializer latency.
